// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

   // EX-stage control-transfer kind
   typedef enum logic [1:0] {
      PC_OP_NONE   = 2'd0,
      PC_OP_BRANCH = 2'd1,
      PC_OP_JAL    = 2'd2,
      PC_OP_JALR   = 2'd3
   } pc_op_t;

   // Branch-condition encodings carried on funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Default trap vector
   localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0040;

endpackage

// File: rtl/pc_gen_branch_cmp.sv
// Combinational branch-condition evaluator: compares two operands under funct3.
module branch_cmp
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      funct3,
   output logic            cond
);

   logic eq_s;
   logic lt_s;
   logic ltu_s;

   assign eq_s  = (rs1 == rs2);
   assign lt_s  = ($signed(rs1) < $signed(rs2));
   assign ltu_s = (rs1 < rs2);

   // Select the condition; reserved encodings resolve to not-taken
   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = eq_s;
         F3_BNE:  cond = ~eq_s;
         F3_BLT:  cond = lt_s;
         F3_BGE:  cond = ~lt_s;
         F3_BLTU: cond = ltu_s;
         F3_BGEU: cond = ~ltu_s;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: PC register, next-PC priority mux, and a one-entry
// pending-redirect register that holds a target resolved during a stall.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     PC_STEP   = 1,
   parameter int unsigned     IMM_SHIFT = 1,
   parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            trap_i,
   input  logic            ex_valid_i,
   input  logic [1:0]      ex_op_i,
   input  logic [2:0]      ex_funct3_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_rs1_i,
   input  logic [XLEN-1:0] ex_rs2_i,
   input  logic [XLEN-1:0] ex_imm_i,
   output logic [XLEN-1:0] pc_o,
   output logic            redirect_o,
   output logic            taken_o,
   output logic [XLEN-1:0] link_o
);

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   pc_op_t          op_s;
   logic            cond_s;
   logic            taken_s;
   logic [XLEN-1:0] offset_s;
   logic [XLEN-1:0] target_s;

   logic [XLEN-1:0] pc_r;
   logic            pend_valid_r;
   logic [XLEN-1:0] pend_pc_r;

   logic [XLEN-1:0] pc_nxt_s;
   logic            pend_valid_nxt_s;
   logic [XLEN-1:0] pend_pc_nxt_s;

   assign op_s = pc_op_t'(ex_op_i);

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .rs1    (ex_rs1_i),
      .rs2    (ex_rs2_i),
      .funct3 (ex_funct3_i),
      .cond   (cond_s)
   );

   // Immediates are pre-scaled for the word-indexed instruction memory
   assign offset_s = XLEN'($signed(ex_imm_i) >>> IMM_SHIFT);

   // Target base: rs1 for JALR, the EX instruction's own PC otherwise
   always_comb begin
      if (op_s == PC_OP_JALR) begin
         target_s = ex_rs1_i + offset_s;
      end else begin
         target_s = ex_pc_i + offset_s;
      end
   end

   // A pending redirect makes everything in EX wrong-path, so it cannot redirect
   always_comb begin
      taken_s = 1'b0;
      if (ex_valid_i && !pend_valid_r) begin
         case (op_s)
            PC_OP_BRANCH: taken_s = cond_s;
            PC_OP_JAL:    taken_s = 1'b1;
            PC_OP_JALR:   taken_s = 1'b1;
            default:      taken_s = 1'b0;
         endcase
      end else begin
         taken_s = 1'b0;
      end
   end

   assign taken_o    = taken_s;
   assign redirect_o = taken_s | trap_i;
   assign link_o     = ex_pc_i + STEP;
   assign pc_o       = pc_r;

   // Next-PC priority: trap, pending release, live redirect, deferred redirect, stall, step
   always_comb begin
      pc_nxt_s         = pc_r;
      pend_valid_nxt_s = pend_valid_r;
      pend_pc_nxt_s    = pend_pc_r;
      if (trap_i) begin
         pc_nxt_s         = TRAP_VEC;
         pend_valid_nxt_s = 1'b0;
      end else if (pend_valid_r && !stall_i) begin
         pc_nxt_s         = pend_pc_r;
         pend_valid_nxt_s = 1'b0;
      end else if (taken_s && !stall_i) begin
         pc_nxt_s = target_s;
      end else if (taken_s && stall_i) begin
         pend_pc_nxt_s    = target_s;
         pend_valid_nxt_s = 1'b1;
      end else if (stall_i) begin
         pc_nxt_s = pc_r;
      end else begin
         pc_nxt_s = pc_r + STEP;
      end
   end

   // PC and pending-redirect state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r         <= RESET_PC;
         pend_valid_r <= 1'b0;
         pend_pc_r    <= {XLEN{1'b0}};
      end else begin
         pc_r         <= pc_nxt_s;
         pend_valid_r <= pend_valid_nxt_s;
         pend_pc_r    <= pend_pc_nxt_s;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: table of per-cycle vectors with a PC scoreboard,
// plus a hand-written asynchronous-reset-during-stall sequence.
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        trap_i;
   logic        ex_valid_i;
   logic [1:0]  ex_op_i;
   logic [2:0]  ex_funct3_i;
   logic [31:0] ex_pc_i;
   logic [31:0] ex_rs1_i;
   logic [31:0] ex_rs2_i;
   logic [31:0] ex_imm_i;
   logic [31:0] pc_o;
   logic        redirect_o;
   logic        taken_o;
   logic [31:0] link_o;

   pc_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall_i),
      .trap_i      (trap_i),
      .ex_valid_i  (ex_valid_i),
      .ex_op_i     (ex_op_i),
      .ex_funct3_i (ex_funct3_i),
      .ex_pc_i     (ex_pc_i),
      .ex_rs1_i    (ex_rs1_i),
      .ex_rs2_i    (ex_rs2_i),
      .ex_imm_i    (ex_imm_i),
      .pc_o        (pc_o),
      .redirect_o  (redirect_o),
      .taken_o     (taken_o),
      .link_o      (link_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        trap;
      logic        valid;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] expc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        e_taken;
      logic        e_redir;
      logic [31:0] e_link;
      logic [31:0] e_pc;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;

   task automatic add(input logic stall, input logic trap, input logic valid,
                      input logic [1:0] op, input logic [2:0] f3,
                      input logic [31:0] expc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm,
                      input logic e_taken, input logic e_redir,
                      input logic [31:0] e_link, input logic [31:0] e_pc);
      vec_t v;
      v.stall = stall; v.trap = trap; v.valid = valid; v.op = op; v.f3 = f3;
      v.expc = expc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
      v.e_taken = e_taken; v.e_redir = e_redir; v.e_link = e_link; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      stall_i = 1'b0; trap_i = 1'b0; ex_valid_i = 1'b0; ex_op_i = 2'd0;
      ex_funct3_i = 3'd0; ex_pc_i = 32'd0; ex_rs1_i = 32'd0; ex_rs2_i = 32'd0;
      ex_imm_i = 32'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      drive_idle();
      rst_n = 1'b0;
      #1;
      check("reset_pc", pc_o, 32'd0);
      check("reset_redirect", {31'd0, redirect_o}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_pc", pc_o, 32'd0);

      // stall trap valid op f3 ex_pc rs1 rs2 imm | taken redir link next_pc
      add(0,0,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,0, 32'd1,  32'd1);
      add(0,0,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,0, 32'd1,  32'd2);
      add(0,0,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,0, 32'd1,  32'd3);
      add(0,0,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,0, 32'd1,  32'd4);
      add(0,0,1,2'd1,3'b000, 32'd10, 32'd5, 32'd5, 32'd8,  1,1, 32'd11, 32'd14);
      add(0,0,1,2'd1,3'b000, 32'd10, 32'd5, 32'd6, 32'd8,  0,0, 32'd11, 32'd15);
      add(0,0,1,2'd1,3'b100, 32'd20, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 1,1, 32'd21, 32'd18);
      add(0,0,1,2'd1,3'b110, 32'd20, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 0,0, 32'd21, 32'd19);
      add(0,0,1,2'd3,3'b000, 32'd30, 32'd100, 32'd0, 32'd6, 1,1, 32'd31, 32'd103);
      add(0,0,1,2'd2,3'b000, 32'd40, 32'd0, 32'd0, 32'd10, 1,1, 32'd41, 32'd45);
      add(0,0,0,2'd2,3'b000, 32'd40, 32'd0, 32'd0, 32'd10, 0,0, 32'd41, 32'd46);
      add(0,0,1,2'd0,3'b000, 32'd40, 32'd0, 32'd0, 32'd10, 0,0, 32'd41, 32'd47);
      add(0,0,1,2'd1,3'b010, 32'd40, 32'd7, 32'd7, 32'd10, 0,0, 32'd41, 32'd48);
      add(0,0,1,2'd1,3'b101, 32'd60, 32'd1, 32'hFFFF_FFFF, 32'd4, 1,1, 32'd61, 32'd62);
      add(0,0,1,2'd1,3'b111, 32'd60, 32'd1, 32'hFFFF_FFFF, 32'd4, 0,0, 32'd61, 32'd63);
      add(0,0,1,2'd1,3'b001, 32'd0,  32'd3, 32'd4, 32'd20, 1,1, 32'd1,  32'd10);
      add(0,1,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,1, 32'd1,  32'h40);
      add(1,0,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,0, 32'd1,  32'h40);
      // redirect under stall: deferred, second redirect ignored, applied on release
      add(1,0,1,2'd1,3'b001, 32'd40, 32'd1, 32'd2, 32'd20, 1,1, 32'd41, 32'h40);
      add(1,0,1,2'd1,3'b000, 32'd60, 32'd5, 32'd5, 32'd20, 0,0, 32'd61, 32'h40);
      add(0,0,1,2'd1,3'b000, 32'd60, 32'd5, 32'd5, 32'd20, 0,0, 32'd61, 32'd50);
      add(0,0,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,0, 32'd1,  32'd51);
      add(0,0,1,2'd1,3'b000, 32'd60, 32'd5, 32'd5, 32'd20, 1,1, 32'd61, 32'd70);
      // trap overrides a pending target while stalled
      add(1,0,1,2'd1,3'b001, 32'd40, 32'd1, 32'd2, 32'd20, 1,1, 32'd41, 32'd70);
      add(1,1,1,2'd1,3'b000, 32'd60, 32'd5, 32'd5, 32'd20, 0,1, 32'd61, 32'h40);
      add(0,0,0,2'd0,3'b000, 32'd0,  32'd0, 32'd0, 32'd0,  0,0, 32'd1,  32'h41);
      add(1,0,1,2'd1,3'b001, 32'd40, 32'd1, 32'd2, 32'd20, 1,1, 32'd41, 32'h41);

      for (int i = 0; i < vecs.size(); i++) begin
         stall_i     = vecs[i].stall;
         trap_i      = vecs[i].trap;
         ex_valid_i  = vecs[i].valid;
         ex_op_i     = vecs[i].op;
         ex_funct3_i = vecs[i].f3;
         ex_pc_i     = vecs[i].expc;
         ex_rs1_i    = vecs[i].rs1;
         ex_rs2_i    = vecs[i].rs2;
         ex_imm_i    = vecs[i].imm;
         #1;
         check($sformatf("taken[%0d]", i), {31'd0, taken_o}, {31'd0, vecs[i].e_taken});
         check($sformatf("redirect[%0d]", i), {31'd0, redirect_o}, {31'd0, vecs[i].e_redir});
         check($sformatf("link[%0d]", i), link_o, vecs[i].e_link);
         exp_q.push_back(vecs[i].e_pc);
         @(posedge clk);
         #1;
         exp_pc = exp_q.pop_front();
         check($sformatf("pc[%0d]", i), pc_o, exp_pc);
      end

      // Async reset mid-stall with a pending target: PC clears without a clock edge
      stall_i = 1'b1;
      drive_idle();
      stall_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_pc", pc_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stall_i = 1'b0;
      exp_q.push_back(32'd1);
      @(posedge clk);
      #1;
      exp_pc = exp_q.pop_front();
      check("after_reset_pend_cleared", pc_o, exp_pc);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter unit: PC register plus next-PC selection for the pipelined core.
- Resolves branch conditions internally from operands (no external zero flag) and supports JAL, JALR, trap vectoring and stall.
- A redirect that resolves during a stall is latched and applied when the stall releases.
- Sits between the hazard unit / EX stage and the instruction-memory address port.

Parameters:
- XLEN, 32, PC/operand width
- PC_STEP, 1, sequential increment (instruction memory is word-indexed)
- IMM_SHIFT, 1, arithmetic right shift applied to immediates before adding to a PC
- RESET_PC, 0, PC value on reset
- TRAP_VEC, 32'h40, PC loaded on trap

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold PC (fetch stalled)
- trap_i  in  1  synchronous trap request, highest priority
- ex_valid_i  in  1  EX-stage instruction valid
- ex_op_i  in  2  0 NONE, 1 BRANCH, 2 JAL, 3 JALR
- ex_funct3_i  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- ex_pc_i  in  XLEN  PC of EX instruction
- ex_rs1_i, ex_rs2_i  in  XLEN  operands
- ex_imm_i  in  XLEN  sign-extended immediate
- pc_o  out  XLEN  current fetch PC (registered)
- redirect_o  out  1  combinational: flush younger stages this cycle
- taken_o  out  1  combinational: EX control transfer taken
- link_o  out  XLEN  ex_pc_i + PC_STEP (JAL/JALR writeback)

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC; pend_valid=0; pend_pc=0. redirect_o/taken_o are 0 whenever ex_valid_i=0 or pend_valid=1.
- Branch target = ex_pc_i + (ex_imm_i >>> IMM_SHIFT), signed shift, modulo 2^XLEN. JAL uses the same target. JALR target = ex_rs1_i + (ex_imm_i >>> IMM_SHIFT).
- Branch condition: signed compares for BLT/BGE, unsigned for BLTU/BGEU. Undefined funct3 values (010, 011) mean not taken.
- taken = ex_valid_i & !pend_valid & (JAL | JALR | BRANCH&cond). redirect_o = taken | trap_i.
- Next-state priority, evaluated each posedge:
  1. trap_i: pc<=TRAP_VEC, pend_valid<=0. Applies even when stalled.
  2. pend_valid & !stall_i: pc<=pend_pc, pend_valid<=0.
  3. taken & !stall_i: pc<=target.
  4. taken & stall_i: pc holds; pend_pc<=target, pend_valid<=1.
  5. stall_i: pc holds.
  6. otherwise: pc<=pc+PC_STEP. Wrap-around at 2^XLEN is silent.
- While pend_valid=1, new EX redirects are ignored; they are wrong-path. Only a trap overrides the pending target.
- Latency: a redirect is visible on pc_o one cycle after resolution, or one cycle after the stall drops.
- ex_op_i=NONE never redirects. link_o is valid regardless of ex_valid_i.

Decomposition:
- Package pc_pkg holds:
  - pc_op_t enum (NONE/BRANCH/JAL/JALR)
  - funct3 branch-condition constants
  - a default-trap-vector localparam
- One sub-module, branch_cmp: combinational condition evaluator (rs1, rs2, funct3 -> cond).
- PC register, pending register and priority mux stay in pc_gen.

Test Plan:
- Reset and sequential: rst_n low then high, no EX activity for 4 cycles -> pc_o 0,1,2,3,4; redirect_o=0.
- BEQ taken: ex_pc=10, rs1=rs2=5, imm=8, funct3=000 -> taken_o=1, redirect_o=1, next pc_o=14. Same with rs2=6 -> not taken, pc_o increments.
- Signed vs unsigned: rs1=32'hFFFF_FFFF, rs2=1: BLT taken, BLTU not taken. Negative imm=-4 at ex_pc=20 -> target 18.
- JALR: rs1=100, imm=6 -> pc_o=103, link_o=ex_pc+1.
- Redirect under stall: stall high, taken BNE target 50 -> pc_o holds. A second taken branch to 70 on the next cycle is ignored (taken_o=0). Stall drops -> pc_o=50, pend_valid cleared.
- Trap priority: pending target 50 and stall high, assert trap_i -> pc_o=TRAP_VEC (0x40), pending discarded. Assert rst_n=0 mid-stall -> pc_o=0 immediately, without waiting for a clock edge.
